// File: rtl/bbcd_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bbcd_seq_ctrl
// Brief    : Sequential binary-to-BCD converter (double-dabble), one step per
//            two clocks, START/BUSY/DONE handshake, registered 4-digit result.
// Revision : 1.0 - initial release
// ============================================================================

module bbcd_seq_ctrl #(
  parameter int N_BITS = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              START,
  input  logic [N_BITS-1:0] BIN,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVF,
  output logic [3:0]        UNIT,
  output logic [3:0]        DEC,
  output logic [3:0]        CENT,
  output logic [3:0]        MIL
);

  localparam int SR_W  = 16 + N_BITS;
  localparam int CNT_W = $clog2(N_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ovf_out_q, ovf_out_d;
  logic [3:0]       unit_q, unit_d;
  logic [3:0]       dec_q, dec_d;
  logic [3:0]       cent_q, cent_d;
  logic [3:0]       mil_q, mil_d;

  logic             bin_ovf;
  logic [SR_W-1:0]  sr_shl;

  // Four BCD digits can only represent values up to 9999.
  assign bin_ovf = (32'(BIN) > 32'd9999);
  assign sr_shl  = {sr_q[SR_W-2:0], 1'b0};

  function automatic logic [3:0] bcd_adj(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      ovf_out_q <= 1'b0;
      unit_q    <= 4'd0;
      dec_q     <= 4'd0;
      cent_q    <= 4'd0;
      mil_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      ovf_out_q <= ovf_out_d;
      unit_q    <= unit_d;
      dec_q     <= dec_d;
      cent_q    <= cent_d;
      mil_q     <= mil_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    ovf_out_d = ovf_out_q;
    unit_d    = unit_q;
    dec_d     = dec_q;
    cent_d    = cent_q;
    mil_d     = mil_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          sr_d    = {16'b0, BIN};
          cnt_d   = CNT_LOAD;
          ovf_d   = bin_ovf;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        for (int k = 0; k < 4; k++) begin
          sr_d[N_BITS + 4*k +: 4] = bcd_adj(sr_q[N_BITS + 4*k +: 4]);
        end
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        sr_d  = sr_shl;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          // Overflowed operands report zero digits rather than a truncated value.
          if (ovf_q) begin
            unit_d = 4'd0;
            dec_d  = 4'd0;
            cent_d = 4'd0;
            mil_d  = 4'd0;
          end else begin
            unit_d = sr_shl[N_BITS      +: 4];
            dec_d  = sr_shl[N_BITS + 4  +: 4];
            cent_d = sr_shl[N_BITS + 8  +: 4];
            mil_d  = sr_shl[N_BITS + 12 +: 4];
          end
          ovf_out_d = ovf_q;
          state_d   = S_DONE;
        end else begin
          state_d = S_CHECK;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign BUSY = (state_q == S_CHECK) || (state_q == S_SHIFT);
  assign DONE = (state_q == S_DONE);
  assign OVF  = ovf_out_q;
  assign UNIT = unit_q;
  assign DEC  = dec_q;
  assign CENT = cent_q;
  assign MIL  = mil_q;

endmodule

`default_nettype wire

// File: tb/tb_bbcd_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bbcd_seq_ctrl
// Brief    : Scoreboard bench for bbcd_seq_ctrl with a decimal reference model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_bbcd_seq_ctrl;

  localparam int N_BITS = 14;
  localparam int LAT    = 2 * N_BITS;

  logic              clk;
  logic              rst;
  logic              START;
  logic [N_BITS-1:0] BIN;
  logic              BUSY;
  logic              DONE;
  logic              OVF;
  logic [3:0]        UNIT;
  logic [3:0]        DEC;
  logic [3:0]        CENT;
  logic [3:0]        MIL;

  bbcd_seq_ctrl #(.N_BITS(N_BITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .START (START),
    .BIN   (BIN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .OVF   (OVF),
    .UNIT  (UNIT),
    .DEC   (DEC),
    .CENT  (CENT),
    .MIL   (MIL)
  );

  typedef struct {
    logic [3:0] u;
    logic [3:0] d;
    logic [3:0] c;
    logic [3:0] m;
    logic       ovf;
    int         acc;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  logic exp_done;
  logic exp_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic exp_t model(input int b, input int acc);
    exp_t e;
    e.ovf = (b > 9999);
    e.u   = e.ovf ? 4'd0 : 4'((b)        % 10);
    e.d   = e.ovf ? 4'd0 : 4'((b / 10)   % 10);
    e.c   = e.ovf ? 4'd0 : 4'((b / 100)  % 10);
    e.m   = e.ovf ? 4'd0 : 4'((b / 1000) % 10);
    e.acc = acc;
    return e;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Monitor: compares handshake and result outputs against the scoreboard head.
  always @(negedge clk) begin
    exp_done = 1'b0;
    exp_busy = 1'b0;
    if (!rst && sb.size() > 0) begin
      exp_done = (cyc == sb[0].acc + LAT);
      exp_busy = (cyc >= sb[0].acc) && (cyc < sb[0].acc + LAT);
    end
    chk("done", {3'b0, DONE}, {3'b0, exp_done});
    chk("busy", {3'b0, BUSY}, {3'b0, exp_busy});
    if (!rst && sb.size() > 0 && cyc >= sb[0].acc + LAT) last = sb.pop_front();
    chk("unit", UNIT, last.u);
    chk("dec",  DEC,  last.d);
    chk("cent", CENT, last.c);
    chk("mil",  MIL,  last.m);
    chk("ovf",  {3'b0, OVF}, {3'b0, last.ovf});
  end

  task automatic conv(input int b);
    @(negedge clk);
    START = 1'b1;
    BIN   = N_BITS'(b);
    sb.push_back(model(b, cyc + 1));
    @(negedge clk);
    START = 1'b0;
    BIN   = N_BITS'($urandom);
  endtask

  task automatic wait_done();
    for (int n = 0; n < 2 * LAT + 10; n++) begin
      @(negedge clk);
      if (DONE === 1'b1) return;
    end
    total++;
    bad++;
    $display("FAIL wait_done: got no DONE expected DONE within %0d cycles", 2 * LAT + 10);
  endtask

  initial begin
    last  = model(0, 0);
    rst   = 1'b1;
    START = 1'b0;
    BIN   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    conv(0);     wait_done();
    conv(1234);  wait_done();
    conv(9999);  wait_done();
    conv(10000); wait_done();
    conv(16383); wait_done();

    // START while busy and during DONE must be dropped.
    conv(5678);
    repeat (8) @(negedge clk);
    START = 1'b1; BIN = N_BITS'(42);
    @(negedge clk);
    START = 1'b0;
    wait_done();
    START = 1'b1; BIN = N_BITS'(42);
    @(negedge clk);
    START = 1'b0;
    repeat (40) @(negedge clk);

    // Reset in the middle of a conversion.
    conv(4321); wait_done();
    conv(77);
    repeat (13) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    last = model(0, 0);
    #1;
    chk("rst_busy", {3'b0, BUSY}, 4'd0);
    chk("rst_done", {3'b0, DONE}, 4'd0);
    chk("rst_ovf",  {3'b0, OVF},  4'd0);
    chk("rst_digits", UNIT | DEC | CENT | MIL, 4'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    conv(77); wait_done();

    for (int i = 0; i < 30; i++) begin
      conv(int'($urandom_range(0, 16383)));
      wait_done();
    end
    conv(1); wait_done();

    repeat (5) @(negedge clk);
    chk("drain", 4'(sb.size()), 4'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
